// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with registered read data and level flags
// Optional sticky overflow/underflow flags with err_clr when FIFO_ERR_FLAG_EN is defined.
module sync_fifo_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
`ifdef FIFO_ERR_FLAG_EN
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow,
`endif
   output logic [ADDR_W:0]   fill_cnt
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_LEVEL);

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];

   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [ADDR_W:0]   fill_w;
   logic              full_w, empty_w;
   logic              wr_acc, rd_acc;

   // Flags decode only from registered pointers, so they move on the same edge as the pointers.
   always_comb begin
      fill_w  = wr_ptr_q - rd_ptr_q;
      full_w  = (fill_w == FULL_CNT);
      empty_w = (fill_w == '0);
      wr_acc  = wr_en & ~full_w;
      rd_acc  = rd_en & ~empty_w;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         data_out_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is intentionally left without reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // A set event in the same cycle as err_clr keeps the flag high.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en && full_w) begin
         overflow_d = 1'b1;
      end
      if (rd_en && empty_w) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

   assign data_out     = data_out_q;
   assign fill_cnt     = fill_w;
   assign full         = full_w;
   assign empty        = empty_w;
   assign almost_full  = (fill_w >= AF_CNT);
   assign almost_empty = (fill_w <= AE_CNT);

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param at default parameters
// Covers FIFO_ERR_FLAG_EN checks when that macro is defined.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic       full, empty, almost_full, almost_empty;
   logic [3:0] fill_cnt;
`ifdef FIFO_ERR_FLAG_EN
   logic       err_clr = 1'b0;
   logic       overflow, underflow;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] model[$];
   logic [7:0] exp_q[$];
   logic       rd_acc_tb = 1'b0;
   logic       mon_rd;
   logic [7:0] last_data = 8'h00;

   sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(wr_en),
      .data_in(data_in),
      .rd_en(rd_en),
      .data_out(data_out),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
`ifdef FIFO_ERR_FLAG_EN
      .err_clr(err_clr),
      .overflow(overflow),
      .underflow(underflow),
`endif
      .fill_cnt(fill_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   // Read data is due one edge after an accepted read; otherwise data_out must hold.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mon_rd <= 1'b0;
      else        mon_rd <= rd_acc_tb;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         last_data = 8'h00;
      end else if (mon_rd) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underrun actual=%0h required=none", data_out);
         end else begin
            last_data = exp_q.pop_front();
         end
      end
      chk("data_out", {24'h0, data_out}, {24'h0, last_data});
   end

   task automatic check_flags();
      int n;
      n = model.size();
      chk("fill_cnt", {28'h0, fill_cnt}, n);
      chk("full", {31'h0, full}, {31'h0, n == 8});
      chk("empty", {31'h0, empty}, {31'h0, n == 0});
      chk("almost_full", {31'h0, almost_full}, {31'h0, n >= 6});
      chk("almost_empty", {31'h0, almost_empty}, {31'h0, n <= 2});
`ifdef FIFO_ERR_FLAG_EN
      chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
      chk("underflow", {31'h0, underflow}, {31'h0, m_unf});
`endif
   endtask

   // Called just after a rising edge; drives one cycle of stimulus and checks flags after the next edge.
   task automatic cycle(input logic w, input logic [7:0] d, input logic r);
      logic wa, ra;
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      wa = w && (model.size() < 8);
      ra = r && (model.size() > 0);
`ifdef FIFO_ERR_FLAG_EN
      m_ovf = (w && model.size() == 8) ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_unf = (r && model.size() == 0) ? 1'b1 : (err_clr ? 1'b0 : m_unf);
`endif
      rd_acc_tb = ra;
      if (ra) exp_q.push_back(model.pop_front());
      if (wa) model.push_back(d);
      @(posedge clk);
      #1;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      rd_acc_tb = 1'b0;
      check_flags();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_flags();
      chk("reset_data_out", {24'h0, data_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill with 0x11..0x88
      for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0);
      chk("full_after_8", {31'h0, full}, 32'h1);
      chk("cnt_after_8", {28'h0, fill_cnt}, 32'h8);
      cycle(1'b1, 8'h99, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
      chk("last_read", {24'h0, data_out}, 32'h88);

      // Read from empty, then clear sticky errors
      cycle(1'b0, 8'h00, 1'b1);
`ifdef FIFO_ERR_FLAG_EN
      err_clr = 1'b1;
      cycle(1'b0, 8'h00, 1'b0);
      err_clr = 1'b0;
`endif
      cycle(1'b0, 8'h00, 1'b0);

      // Steady level of 4 with concurrent traffic; pointers wrap several times
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
      for (int i = 4; i < 24; i++) cycle(1'b1, 8'(8'h20 + i), 1'b1);
      chk("steady_cnt", {28'h0, fill_cnt}, 32'h4);

      // Full with simultaneous read and write
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
      cycle(1'b1, 8'hEE, 1'b1);
      chk("full_rw_cnt", {28'h0, fill_cnt}, 32'h7);
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);

      // Empty with simultaneous read and write
      cycle(1'b1, 8'h5A, 1'b1);
      chk("empty_rw_cnt", {28'h0, fill_cnt}, 32'h1);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
      chk("empty_rw_read", {24'h0, data_out}, 32'h5A);

      // Reset in the middle of a cycle with words stored
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
      #2;
      rst_n = 1'b0;
      model.delete();
      exp_q.delete();
`ifdef FIFO_ERR_FLAG_EN
      m_ovf = 1'b0;
      m_unf = 1'b0;
`endif
      #1;
      check_flags();
      chk("async_rst_data_out", {24'h0, data_out}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 8'hA5, 1'b0);
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
      chk("post_rst_read", {24'h0, data_out}, 32'hA5);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
